// File: rtl/snake_pkg.sv
`default_nettype none
// snake_pkg -- shared grid geometry, cell type, apple-spawner FSM states and LFSR taps.
// Rev 1.0
package snake_pkg;

   localparam int GRID_W_DEF  = 20;
   localparam int GRID_H_DEF  = 15;
   localparam int CELL_PX_DEF = 32;

   // Feedback taps 16,14,13,11 expressed as a mask over q[15:0]
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef struct packed {
      logic [4:0] cx;
      logic [3:0] cy;
   } cell_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PICK   = 3'd1,
      S_QUERY  = 3'd2,
      S_WAIT   = 3'd3,
      S_COMMIT = 3'd4,
      S_SCAN   = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// lfsr16 -- free-running 16-bit Fibonacci LFSR; a nonzero seed keeps it off the all-zero lockup state.
// Rev 1.0
module lfsr16
   import snake_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
)(
   input  logic        clk,
   input  logic        resetN,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) q <= SEED;
      else         q <= {q[14:0], ^(q & LFSR_TAPS)};
   end

endmodule
`default_nettype wire

// File: rtl/apple_spawner.sv
`default_nettype none
// apple_spawner -- tracks NUM_APPLES apple slots, scores eats and respawns eaten apples on free cells.
// Rev 1.0
module apple_spawner
   import snake_pkg::*;
#(
   parameter int          NUM_APPLES = 3,
   parameter int          GRID_W     = GRID_W_DEF,
   parameter int          GRID_H     = GRID_H_DEF,
   parameter int          CELL_PX    = CELL_PX_DEF,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          MAX_TRIES  = 16,
   parameter int          SCORE_W    = 16
)(
   input  logic                                              clk,
   input  logic                                              resetN,
   input  logic                                              eat,
   input  logic [((NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1)-1:0] eat_idx,
   output logic                                              occ_req,
   output logic [4:0]                                        occ_cx,
   output logic [3:0]                                        occ_cy,
   input  logic                                              occ_ack,
   input  logic                                              occ_hit,
   output logic [NUM_APPLES*11-1:0]                          apple_x,
   output logic [NUM_APPLES*10-1:0]                          apple_y,
   output logic [NUM_APPLES-1:0]                             apple_valid,
   output logic [SCORE_W-1:0]                                score,
   output logic                                              busy,
   output logic                                              grid_full
);

   localparam int IDX_W  = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;
   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int SHIFT  = $clog2(CELL_PX);
   localparam int NCELLS = GRID_W * GRID_H;

   state_t                state, state_n;
   cell_t                 pos [NUM_APPLES];
   cell_t                 cand, cand_next, lfsr_cell;
   logic [15:0]           lfsr_q;
   logic [NUM_APPLES-1:0] pending;
   logic [IDX_W-1:0]      slot, low_idx;
   logic [TRY_W-1:0]      tries;
   logic [9:0]            scan_cnt;
   logic                  scan_mode, eat_prev, eat_edge, eat_accept;
   logic                  lfsr_ok, lfsr_clash, cand_clash, tries_last, scan_done;
   logic                  reject, scan_step, scan_fail;
   logic                  unused_lfsr;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .resetN (resetN),
      .q      (lfsr_q)
   );

   assign lfsr_cell   = {lfsr_q[4:0], lfsr_q[8:5]};
   assign unused_lfsr = ^lfsr_q[15:9];
   assign eat_edge    = eat && !eat_prev;
   assign lfsr_ok     = (int'(lfsr_cell.cx) < GRID_W) && (int'(lfsr_cell.cy) < GRID_H) && !lfsr_clash;
   assign tries_last  = (int'(tries) + 1 >= MAX_TRIES);
   assign scan_done   = (scan_cnt == 10'(NCELLS));

   // The slot under respawn is invalid, so it never blocks its own candidate.
   always_comb begin
      lfsr_clash = 1'b0;
      cand_clash = 1'b0;
      eat_accept = 1'b0;
      low_idx    = '0;
      for (int i = 0; i < NUM_APPLES; i++) begin
         if (apple_valid[i] && pos[i] == lfsr_cell) lfsr_clash = 1'b1;
         if (apple_valid[i] && pos[i] == cand)      cand_clash = 1'b1;
         if (eat_edge && eat_idx == IDX_W'(i) && apple_valid[i]) eat_accept = 1'b1;
      end
      for (int i = NUM_APPLES - 1; i >= 0; i--) begin
         if (pending[i]) low_idx = IDX_W'(i);
      end
   end

   always_comb begin
      cand_next = cand;
      if (int'(cand.cx) >= GRID_W - 1) begin
         cand_next.cx = '0;
         cand_next.cy = cand.cy + 4'd1;
      end else begin
         cand_next.cx = cand.cx + 5'd1;
      end
   end

   always_comb begin
      state_n   = state;
      reject    = 1'b0;
      scan_step = 1'b0;
      scan_fail = 1'b0;
      case (state)
         S_IDLE:   if (pending != '0) state_n = S_PICK;
         S_PICK: begin
            if (lfsr_ok) begin
               state_n = S_QUERY;
            end else begin
               reject  = 1'b1;
               state_n = tries_last ? S_SCAN : S_PICK;
            end
         end
         S_QUERY:  state_n = S_WAIT;
         S_WAIT: begin
            if (occ_ack) begin
               if (!occ_hit) begin
                  state_n = S_COMMIT;
               end else if (scan_mode) begin
                  scan_step = 1'b1;
                  state_n   = S_SCAN;
               end else begin
                  reject  = 1'b1;
                  state_n = tries_last ? S_SCAN : S_PICK;
               end
            end
         end
         S_COMMIT: state_n = S_IDLE;
         S_SCAN: begin
            if (scan_done) begin
               scan_fail = 1'b1;
               state_n   = S_IDLE;
            end else if (cand_clash) begin
               scan_step = 1'b1;
            end else begin
               state_n = S_QUERY;
            end
         end
         default:  state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= S_IDLE;
         eat_prev    <= 1'b0;
         pending     <= '0;
         apple_valid <= '1;
         score       <= '0;
         grid_full   <= 1'b0;
         slot        <= '0;
         tries       <= '0;
         scan_mode   <= 1'b0;
         scan_cnt    <= '0;
         cand        <= '0;
         for (int i = 0; i < NUM_APPLES; i++) pos[i] <= '{cx: 5'(4 + 2*i), cy: 4'd3};
      end else begin
         state    <= state_n;
         eat_prev <= eat;
         if (state == S_IDLE && pending != '0) begin
            slot      <= low_idx;
            tries     <= '0;
            scan_mode <= 1'b0;
         end
         if (state == S_PICK && lfsr_ok) cand <= lfsr_cell;
         if (reject) begin
            tries <= tries + 1'b1;
            if (tries_last) begin
               scan_mode <= 1'b1;
               scan_cnt  <= '0;
               cand      <= '0;
            end
         end
         if (scan_step) begin
            cand     <= cand_next;
            scan_cnt <= scan_cnt + 10'd1;
         end
         if (scan_fail) grid_full <= 1'b1;
         for (int i = 0; i < NUM_APPLES; i++) begin
            if (slot == IDX_W'(i) && state == S_COMMIT) begin
               pos[i]         <= cand;
               apple_valid[i] <= 1'b1;
               pending[i]     <= 1'b0;
            end
            if (slot == IDX_W'(i) && scan_fail) pending[i] <= 1'b0;
            if (eat_edge && eat_idx == IDX_W'(i) && apple_valid[i]) begin
               apple_valid[i] <= 1'b0;
               pending[i]     <= 1'b1;
            end
         end
         if (eat_accept && score != '1) score <= score + 1'b1;
      end
   end

   assign occ_req = (state == S_QUERY) || (state == S_WAIT);
   assign occ_cx  = cand.cx;
   assign occ_cy  = cand.cy;
   assign busy    = (state != S_IDLE);

   // Pixel position is derived from the stored cell, so it changes on the same edge as valid.
   generate
      for (genvar g = 0; g < NUM_APPLES; g++) begin : g_pix
         assign apple_x[g*11 +: 11] = 11'(pos[g].cx) << SHIFT;
         assign apple_y[g*10 +: 10] = 10'(pos[g].cy) << SHIFT;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apple_spawner.sv
`default_nettype none
// tb_apple_spawner -- directed + randomized bench with an abstract slot/score model and a modelled body tracker.
// Rev 1.0
module tb_apple_spawner;

   localparam int N  = 3;
   localparam int CP = 32;

   logic          clk = 1'b0;
   logic          resetN, eat;
   logic [1:0]    eat_idx;
   logic          occ_req, occ_ack, occ_hit;
   logic [4:0]    occ_cx;
   logic [3:0]    occ_cy;
   logic [N*11-1:0] apple_x;
   logic [N*10-1:0] apple_y;
   logic [N-1:0]  apple_valid;
   logic [15:0]   score;
   logic          busy, grid_full;

   int total = 0;
   int bad   = 0;
   int tr_mode = 0, tr_delay = 0, tr_hit_n = 0, tr_tcx = 7, tr_tcy = 2;
   int q_count = 0, last_mcx = -1, last_mcy = -1;
   int mx [N];
   int my [N];
   bit [N-1:0] mvalid;
   int mscore;
   int order [$];

   apple_spawner #(.NUM_APPLES(N)) dut (
      .clk         (clk),
      .resetN      (resetN),
      .eat         (eat),
      .eat_idx     (eat_idx),
      .occ_req     (occ_req),
      .occ_cx      (occ_cx),
      .occ_cy      (occ_cy),
      .occ_ack     (occ_ack),
      .occ_hit     (occ_hit),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .apple_valid (apple_valid),
      .score       (score),
      .busy        (busy),
      .grid_full   (grid_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ax(input int s);
      return int'(apple_x[s*11 +: 11]);
   endfunction

   function automatic int ay(input int s);
      return int'(apple_y[s*10 +: 10]);
   endfunction

   function automatic int ord(input int k);
      return (k < order.size()) ? order[k] : -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mx[i] = 4 + 2*i;
         my[i] = 3;
      end
      mvalid = '1;
      mscore = 0;
   endtask

   task automatic check_all();
      check("valid_vec", apple_valid, mvalid);
      check("score", score, mscore);
      for (int i = 0; i < N; i++) begin
         if (mvalid[i]) begin
            check($sformatf("pos_x%0d", i), ax(i), mx[i]*CP);
            check($sformatf("pos_y%0d", i), ay(i), my[i]*CP);
         end
      end
   endtask

   // A respawned slot must sit on the cell the tracker last declared free, on-grid, clear of live apples.
   task automatic check_respawn(input int s);
      check($sformatf("resp_valid%0d", s), apple_valid[s], 1);
      check($sformatf("resp_x%0d", s), ax(s), last_mcx*CP);
      check($sformatf("resp_y%0d", s), ay(s), last_mcy*CP);
      check("resp_in_screen", (ax(s) < 640 && ay(s) < 480 && ax(s) % CP == 0 && ay(s) % CP == 0), 1);
      for (int j = 0; j < N; j++) begin
         if (j != s && mvalid[j])
            check($sformatf("resp_overlap%0d_%0d", s, j), (mx[j] == last_mcx && my[j] == last_mcy), 0);
      end
      mx[s] = last_mcx;
      my[s] = last_mcy;
      mvalid[s] = 1'b1;
   endtask

   task automatic do_eat(input int idx, input int hold, output bit acc);
      @(negedge clk);
      eat     = 1'b1;
      eat_idx = 2'(idx);
      acc     = 1'b0;
      if (idx < N) acc = mvalid[idx];
      if (acc) begin
         mvalid[idx] = 1'b0;
         mscore++;
      end
      repeat (hold) @(negedge clk);
      eat = 1'b0;
   endtask

   task automatic wait_settle(input int budget);
      int idle = 0;
      int n    = 0;
      repeat (3) @(negedge clk);
      while (idle < 2 && n < budget) begin
         @(negedge clk);
         n++;
         idle = busy ? 0 : idle + 1;
      end
      check("settle_in_budget", (idle >= 2), 1);
   endtask

   // Body tracker model: answers each request after tr_delay WAIT cycles.
   initial begin
      bit in_flight = 0;
      int cnt = 0, lcx = 0, lcy = 0;
      bit hit;
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      forever begin
         @(negedge clk);
         occ_ack = 1'b0;
         occ_hit = 1'b0;
         if (!resetN) begin
            in_flight = 0;
         end else if (!in_flight) begin
            if (occ_req) begin
               in_flight = 1;
               cnt = tr_delay;
               lcx = int'(occ_cx);
               lcy = int'(occ_cy);
               check("query_on_grid", (lcx < 20 && lcy < 15), 1);
            end
         end else begin
            check("req_held", occ_req, 1);
            check("cx_stable", occ_cx, lcx);
            check("cy_stable", occ_cy, lcy);
            if (cnt == 0) begin
               case (tr_mode)
                  0:       hit = 0;
                  1:       hit = (q_count < tr_hit_n);
                  2:       hit = !(lcx == tr_tcx && lcy == tr_tcy);
                  default: hit = 1;
               endcase
               q_count++;
               if (!hit) begin
                  last_mcx = lcx;
                  last_mcy = lcy;
               end
               occ_ack = 1'b1;
               occ_hit = hit;
               in_flight = 0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin
      bit acc;
      int n;
      logic [N-1:0] prev;
      resetN  = 1'b0;
      eat     = 1'b0;
      eat_idx = '0;
      model_reset();
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_req", occ_req, 0);
      check("rst_full", grid_full, 0);
      check("rst_x0", ax(0), 128);
      check("rst_x1", ax(1), 192);
      check("rst_x2", ax(2), 256);
      check("rst_y1", ay(1), 96);
      check_all();

      // Held eat on slot 1 scores once; tracker acks free after 2 cycles
      tr_mode = 0; tr_delay = 2;
      eat = 1'b1; eat_idx = 2'd1;
      mvalid[1] = 1'b0; mscore++;
      @(negedge clk);
      check("eat_valid_low", apple_valid[1], 0);
      check("eat_score", score, 1);
      repeat (9) @(negedge clk);
      eat = 1'b0;
      wait_settle(1000);
      check_respawn(1);
      check_all();

      // First three queries hit: exactly four handshakes
      tr_mode = 1; tr_hit_n = 3; tr_delay = 1; q_count = 0;
      do_eat(0, 1, acc);
      wait_settle(2000);
      check("handshakes", q_count, 4);
      check_respawn(0);
      check_all();

      // Random phase always rejected; scan finds the single free cell
      tr_tcx = 7; tr_tcy = 2;
      for (int j = 0; j < N; j++)
         if (j != 2 && mvalid[j] && mx[j] == 7 && my[j] == 2) begin tr_tcx = 12; tr_tcy = 11; end
      tr_mode = 2; tr_delay = 0;
      do_eat(2, 2, acc);
      wait_settle(5000);
      check("scan_x", ax(2), tr_tcx*CP);
      check("scan_y", ay(2), tr_tcy*CP);
      check_respawn(2);
      check_all();

      // Randomized eats, including out-of-range index 3
      for (int r = 0; r < 8; r++) begin
         int idx;
         idx = int'($urandom_range(0, 3));
         tr_mode = 0;
         tr_delay = int'($urandom_range(0, 3));
         do_eat(idx, int'($urandom_range(1, 4)), acc);
         wait_settle(2000);
         if (acc) check_respawn(idx);
         check_all();
      end

      // Slot 1 respawning slowly while slots 2 then 0 are eaten: order 1, 0, 2
      tr_mode = 0; tr_delay = 8;
      do_eat(1, 1, acc);
      repeat (2) @(negedge clk);
      do_eat(2, 1, acc);
      do_eat(0, 1, acc);
      prev = apple_valid;
      n = 0;
      while (order.size() < 3 && n < 3000) begin
         @(negedge clk);
         n++;
         for (int s = 0; s < N; s++)
            if (apple_valid[s] && !prev[s]) begin
               order.push_back(s);
               check_respawn(s);
            end
         prev = apple_valid;
      end
      check("order_cnt", order.size(), 3);
      check("order0", ord(0), 1);
      check("order1", ord(1), 0);
      check("order2", ord(2), 2);
      wait_settle(200);
      check_all();

      // Every query hits through the full scan: grid_full, slot left invalid
      tr_mode = 3; tr_delay = 0;
      do_eat(1, 1, acc);
      wait_settle(6000);
      check("full_flag", grid_full, 1);
      check("full_slot_invalid", apple_valid[1], 0);
      repeat (5) @(negedge clk);
      check("full_pending_clear", busy, 0);
      check_all();

      // Eat on an invalid slot is ignored
      do_eat(1, 1, acc);
      wait_settle(100);
      check("dead_eat_busy", busy, 0);
      check_all();

      // Reset during WAIT
      tr_mode = 0; tr_delay = 20;
      do_eat(0, 1, acc);
      n = 0;
      while (!occ_req && n < 100) begin @(negedge clk); n++; end
      check("req_seen", occ_req, 1);
      repeat (3) @(negedge clk);
      check("req_in_wait", occ_req, 1);
      #2 resetN = 1'b0;
      #1;
      model_reset();
      check("mid_rst_req", occ_req, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_full", grid_full, 0);
      check_all();
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_req", occ_req, 0);
      check_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
